// File: rtl/cpu_hazard_ctrl.sv
// cpu_hazard_ctrl
// Pipeline scheduler for the 5-stage core (IF/DEC/EX/MEM/WB). It tracks the
// destination registers of the instructions in EX, MEM and WB in a small
// scoreboard. From that scoreboard, the decode hazard bus and the cache
// acknowledges it produces these controls for the front of the pipe:
//   - stall, kill and forwarding selects;
//   - branch-flush and cache-miss sequencing;
//   - a saturating count of fetch-stall cycles.
//
// Ports
//   hzd_clk, hzd_rst   clock (rising edge), asynchronous active-high reset
//   hzd_dec_bus        {rs1, rs2, rd} of the instruction in DEC (0 = unused)
//   hzd_dec_valid      DEC holds a real instruction
//   hzd_dec_we         DEC instruction writes the register file
//   hzd_dec_load       DEC instruction is a load
//   hzd_brnch_taken    EX resolved a taken branch or jump
//   hzd_il1_ack        instruction cache returned the fetch this cycle
//   hzd_mem_req        MEM stage holds a load or store
//   hzd_dl1_ack        data cache completed the MEM access
//   hzd_stall_if       hold PC and fetch register
//   hzd_stall_dec      hold DEC register
//   hzd_kill_dec       bubble out of DEC
//   hzd_kill_ex        bubble out of EX
//   hzd_freeze         hold EX/MEM/WB registers
//   hzd_fwd_src1/2     00 regfile, 01 EX, 10 MEM, 11 WB
//   hzd_state          FSM state (00 RUN, 01 FLUSH, 10 IMISS, 11 DMISS)
//   hzd_stall_cnt      saturating count of cycles with hzd_stall_if=1
module cpu_hazard_ctrl #(
  parameter int RA_W         = 5,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic              hzd_clk,
  input  logic              hzd_rst,
  input  logic [3*RA_W-1:0] hzd_dec_bus,
  input  logic              hzd_dec_valid,
  input  logic              hzd_dec_we,
  input  logic              hzd_dec_load,
  input  logic              hzd_brnch_taken,
  input  logic              hzd_il1_ack,
  input  logic              hzd_mem_req,
  input  logic              hzd_dl1_ack,
  output logic              hzd_stall_if,
  output logic              hzd_stall_dec,
  output logic              hzd_kill_dec,
  output logic              hzd_kill_ex,
  output logic              hzd_freeze,
  output logic [1:0]        hzd_fwd_src1,
  output logic [1:0]        hzd_fwd_src2,
  output logic [1:0]        hzd_state,
  output logic [CNT_W-1:0]  hzd_stall_cnt
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_FLUSH = 2'b01,
    ST_IMISS = 2'b10,
    ST_DMISS = 2'b11
  } state_t;

  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

  state_t state_q;
  logic [1:0] flush_cnt;
  logic flush_first;
  logic flush_susp;

  // The load flag only matters for the EX entry (load-use detection),
  // so MEM and WB keep just valid and rd.
  logic ex_valid, ex_load, mem_valid, wb_valid;
  logic [RA_W-1:0] ex_rd, mem_rd, wb_rd;

  logic [RA_W-1:0] rs1, rs2, rd;
  logic miss_c, eff_flush, load_use_c;
  logic stall_if_c, stall_dec_c, kill_dec_c, kill_ex_c, freeze_c;

  assign rs1 = hzd_dec_bus[3*RA_W-1:2*RA_W];
  assign rs2 = hzd_dec_bus[2*RA_W-1:RA_W];
  assign rd  = hzd_dec_bus[RA_W-1:0];

  assign miss_c = hzd_mem_req & ~hzd_dl1_ack;

  // A flush interrupted by a data miss resumes where it left off once the
  // freeze lifts, since the wrong-path instructions were held, not dropped.
  assign eff_flush = (state_q == ST_FLUSH) | ((state_q == ST_DMISS) & flush_susp);

  assign load_use_c = hzd_dec_valid & ex_valid & ex_load &
                      (((rs1 != '0) & (ex_rd == rs1)) | ((rs2 != '0) & (ex_rd == rs2)));

  // Youngest producer wins. A load still in EX has no result yet, so it
  // selects nothing (the load-use stall covers that cycle).
  function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] src,
                                         input logic ev, input logic el,
                                         input logic [RA_W-1:0] er,
                                         input logic mv, input logic [RA_W-1:0] mr,
                                         input logic wv, input logic [RA_W-1:0] wr);
    fwd_sel = 2'b00;
    if (src != '0) begin
      if (ev && er == src)      fwd_sel = el ? 2'b00 : 2'b01;
      else if (mv && mr == src) fwd_sel = 2'b10;
      else if (wv && wr == src) fwd_sel = 2'b11;
    end
  endfunction

  // Control decode, highest priority first: data miss, flush, load-use,
  // instruction miss. Everything is forced quiet while reset is held.
  always_comb begin
    stall_if_c  = 1'b0;
    stall_dec_c = 1'b0;
    kill_dec_c  = 1'b0;
    kill_ex_c   = 1'b0;
    freeze_c    = 1'b0;
    if (!hzd_rst) begin
      if (miss_c) begin
        freeze_c    = 1'b1;
        stall_if_c  = 1'b1;
        stall_dec_c = 1'b1;
      end else if (eff_flush) begin
        kill_dec_c = 1'b1;
        kill_ex_c  = flush_first;
      end else if (load_use_c) begin
        stall_if_c  = 1'b1;
        stall_dec_c = 1'b1;
      end else if (!hzd_il1_ack) begin
        stall_if_c = 1'b1;
        kill_dec_c = 1'b1;
      end
    end
  end

  assign hzd_stall_if  = hzd_rst | stall_if_c;
  assign hzd_stall_dec = stall_dec_c;
  assign hzd_kill_dec  = kill_dec_c;
  assign hzd_kill_ex   = kill_ex_c;
  assign hzd_freeze    = freeze_c;
  assign hzd_state     = state_q;
  assign hzd_fwd_src1  = fwd_sel(rs1, ex_valid, ex_load, ex_rd, mem_valid, mem_rd, wb_valid, wb_rd);
  assign hzd_fwd_src2  = fwd_sel(rs2, ex_valid, ex_load, ex_rd, mem_valid, mem_rd, wb_valid, wb_rd);

  // FSM. A branch held in EX during a data miss is simply seen again on the
  // release cycle, so no pending-branch flag is needed.
  always_ff @(posedge hzd_clk or posedge hzd_rst) begin
    if (hzd_rst) begin
      state_q     <= ST_RUN;
      flush_cnt   <= 2'd0;
      flush_first <= 1'b0;
      flush_susp  <= 1'b0;
    end else if (miss_c) begin
      state_q    <= ST_DMISS;
      flush_susp <= eff_flush;
    end else if (eff_flush) begin
      flush_susp  <= 1'b0;
      flush_first <= 1'b0;
      if (flush_cnt == 2'd0) begin
        state_q <= ST_RUN;
      end else begin
        state_q   <= ST_FLUSH;
        flush_cnt <= flush_cnt - 2'd1;
      end
    end else if (hzd_brnch_taken) begin
      state_q     <= ST_FLUSH;
      flush_cnt   <= FLUSH_LOAD;
      flush_first <= 1'b1;
    end else if (!hzd_il1_ack) begin
      state_q <= ST_IMISS;
    end else begin
      state_q <= ST_RUN;
    end
  end

  // Scoreboard shift. An instruction killed in EX must not be forwarded
  // from later, so it enters MEM as invalid.
  always_ff @(posedge hzd_clk or posedge hzd_rst) begin
    if (hzd_rst) begin
      ex_valid  <= 1'b0;
      ex_load   <= 1'b0;
      ex_rd     <= '0;
      mem_valid <= 1'b0;
      mem_rd    <= '0;
      wb_valid  <= 1'b0;
      wb_rd     <= '0;
    end else if (!freeze_c) begin
      ex_valid  <= hzd_dec_valid & hzd_dec_we & (rd != '0) & ~stall_dec_c & ~kill_dec_c;
      ex_load   <= hzd_dec_load;
      ex_rd     <= rd;
      mem_valid <= ex_valid & ~kill_ex_c;
      mem_rd    <= ex_rd;
      wb_valid  <= mem_valid;
      wb_rd     <= mem_rd;
    end
  end

  always_ff @(posedge hzd_clk or posedge hzd_rst) begin
    if (hzd_rst) begin
      hzd_stall_cnt <= '0;
    end else if (stall_if_c && hzd_stall_cnt != '1) begin
      hzd_stall_cnt <= hzd_stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_cpu_hazard_ctrl.sv
// Directed testbench for cpu_hazard_ctrl. A second instance with a 3-bit
// stall counter shares all inputs so counter saturation can be reached quickly.
module tb_cpu_hazard_ctrl;

  localparam logic [1:0] ST_RUN   = 2'b00;
  localparam logic [1:0] ST_FLUSH = 2'b01;
  localparam logic [1:0] ST_IMISS = 2'b10;
  localparam logic [1:0] ST_DMISS = 2'b11;

  logic        hzd_clk;
  logic        hzd_rst;
  logic [14:0] hzd_dec_bus;
  logic        hzd_dec_valid, hzd_dec_we, hzd_dec_load;
  logic        hzd_brnch_taken, hzd_il1_ack, hzd_mem_req, hzd_dl1_ack;
  logic        hzd_stall_if, hzd_stall_dec, hzd_kill_dec, hzd_kill_ex, hzd_freeze;
  logic [1:0]  hzd_fwd_src1, hzd_fwd_src2, hzd_state;
  logic [15:0] hzd_stall_cnt;

  logic        s_stall_if, s_stall_dec, s_kill_dec, s_kill_ex, s_freeze;
  logic [1:0]  s_fwd_src1, s_fwd_src2, s_state;
  logic [2:0]  s_stall_cnt;

  int checkCount;
  int errorCount;

  cpu_hazard_ctrl dut (
    .hzd_clk(hzd_clk), .hzd_rst(hzd_rst), .hzd_dec_bus(hzd_dec_bus),
    .hzd_dec_valid(hzd_dec_valid), .hzd_dec_we(hzd_dec_we), .hzd_dec_load(hzd_dec_load),
    .hzd_brnch_taken(hzd_brnch_taken), .hzd_il1_ack(hzd_il1_ack),
    .hzd_mem_req(hzd_mem_req), .hzd_dl1_ack(hzd_dl1_ack),
    .hzd_stall_if(hzd_stall_if), .hzd_stall_dec(hzd_stall_dec),
    .hzd_kill_dec(hzd_kill_dec), .hzd_kill_ex(hzd_kill_ex), .hzd_freeze(hzd_freeze),
    .hzd_fwd_src1(hzd_fwd_src1), .hzd_fwd_src2(hzd_fwd_src2),
    .hzd_state(hzd_state), .hzd_stall_cnt(hzd_stall_cnt)
  );

  cpu_hazard_ctrl #(.CNT_W(3)) dut_small (
    .hzd_clk(hzd_clk), .hzd_rst(hzd_rst), .hzd_dec_bus(hzd_dec_bus),
    .hzd_dec_valid(hzd_dec_valid), .hzd_dec_we(hzd_dec_we), .hzd_dec_load(hzd_dec_load),
    .hzd_brnch_taken(hzd_brnch_taken), .hzd_il1_ack(hzd_il1_ack),
    .hzd_mem_req(hzd_mem_req), .hzd_dl1_ack(hzd_dl1_ack),
    .hzd_stall_if(s_stall_if), .hzd_stall_dec(s_stall_dec),
    .hzd_kill_dec(s_kill_dec), .hzd_kill_ex(s_kill_ex), .hzd_freeze(s_freeze),
    .hzd_fwd_src1(s_fwd_src1), .hzd_fwd_src2(s_fwd_src2),
    .hzd_state(s_state), .hzd_stall_cnt(s_stall_cnt)
  );

  initial begin
    hzd_clk = 1'b0;
    forever #5 hzd_clk = ~hzd_clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of inputs just after the falling edge, then leave time
  // for combinational outputs to settle before checks run.
  task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic valid,
                               input logic we, input logic load, input logic br,
                               input logic il1, input logic mreq, input logic dack);
    @(negedge hzd_clk);
    hzd_dec_bus     = {rs1, rs2, rd};
    hzd_dec_valid   = valid;
    hzd_dec_we      = we;
    hzd_dec_load    = load;
    hzd_brnch_taken = br;
    hzd_il1_ack     = il1;
    hzd_mem_req     = mreq;
    hzd_dl1_ack     = dack;
    #2;
  endtask

  task automatic applyIdle(input logic il1);
    applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, il1, 1'b0, 1'b0);
  endtask

  task automatic resetDut();
    @(negedge hzd_clk);
    hzd_rst = 1'b1;
    #2;
    @(negedge hzd_clk);
    hzd_rst = 1'b0;
  endtask

  initial begin
    checkCount      = 0;
    errorCount      = 0;
    hzd_rst         = 1'b1;
    hzd_dec_bus     = '0;
    hzd_dec_valid   = 1'b0;
    hzd_dec_we      = 1'b0;
    hzd_dec_load    = 1'b0;
    hzd_brnch_taken = 1'b0;
    hzd_il1_ack     = 1'b1;
    hzd_mem_req     = 1'b0;
    hzd_dl1_ack     = 1'b0;
    #2;
    checkOutput("rst_stall_if", 32'(hzd_stall_if), 32'd1);
    checkOutput("rst_freeze", 32'(hzd_freeze), 32'd0);
    checkOutput("rst_kill_dec", 32'(hzd_kill_dec), 32'd0);
    checkOutput("rst_state", 32'(hzd_state), 32'(ST_RUN));
    checkOutput("rst_cnt", 32'(hzd_stall_cnt), 32'd0);
    @(negedge hzd_clk);
    hzd_rst = 1'b0;

    // Back-to-back ALU dependencies through EX, MEM and WB
    applyStimulus(5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("alu_no_stall", 32'(hzd_stall_if), 32'd0);
    applyStimulus(5'd5, 5'd0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("fwd1_ex", 32'(hzd_fwd_src1), 32'd1);
    checkOutput("alu_no_stall_dec", 32'(hzd_stall_dec), 32'd0);
    applyStimulus(5'd5, 5'd6, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("fwd1_mem", 32'(hzd_fwd_src1), 32'd2);
    checkOutput("fwd2_ex", 32'(hzd_fwd_src2), 32'd1);
    applyStimulus(5'd5, 5'd6, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("fwd1_wb", 32'(hzd_fwd_src1), 32'd3);
    checkOutput("fwd2_mem", 32'(hzd_fwd_src2), 32'd2);
    applyIdle(1'b1);

    // Load-use: lw x7 then a consumer of x7
    applyStimulus(5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("lw_no_stall", 32'(hzd_stall_if), 32'd0);
    applyStimulus(5'd0, 5'd7, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("lu_stall_if", 32'(hzd_stall_if), 32'd1);
    checkOutput("lu_stall_dec", 32'(hzd_stall_dec), 32'd1);
    checkOutput("lu_kill_dec", 32'(hzd_kill_dec), 32'd0);
    applyStimulus(5'd0, 5'd7, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("lu_released", 32'(hzd_stall_dec), 32'd0);
    checkOutput("lu_fwd2_mem", 32'(hzd_fwd_src2), 32'd2);
    checkOutput("lu_cnt", 32'(hzd_stall_cnt), 32'd1);

    // x0 destination never becomes a producer
    applyStimulus(5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(5'd0, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("x0_fwd1", 32'(hzd_fwd_src1), 32'd0);
    checkOutput("x0_fwd2_mem", 32'(hzd_fwd_src2), 32'd2);
    checkOutput("x0_no_stall", 32'(hzd_stall_if), 32'd0);
    applyIdle(1'b1);

    // Taken branch with two flush cycles
    applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("br_state_run", 32'(hzd_state), 32'(ST_RUN));
    checkOutput("br_kill_ex_early", 32'(hzd_kill_ex), 32'd0);
    applyIdle(1'b1);
    checkOutput("fl1_state", 32'(hzd_state), 32'(ST_FLUSH));
    checkOutput("fl1_kill_ex", 32'(hzd_kill_ex), 32'd1);
    checkOutput("fl1_kill_dec", 32'(hzd_kill_dec), 32'd1);
    applyIdle(1'b0);
    checkOutput("fl2_state", 32'(hzd_state), 32'(ST_FLUSH));
    checkOutput("fl2_kill_ex", 32'(hzd_kill_ex), 32'd0);
    checkOutput("fl2_kill_dec", 32'(hzd_kill_dec), 32'd1);
    checkOutput("fl2_imiss_masked", 32'(hzd_stall_if), 32'd0);
    applyIdle(1'b1);
    checkOutput("fl3_state_run", 32'(hzd_state), 32'(ST_RUN));
    checkOutput("fl3_kill_dec", 32'(hzd_kill_dec), 32'd0);

    // Data miss for four cycles with a branch held in EX from cycle 2
    resetDut();
    applyStimulus(5'd0, 5'd0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(5'd9, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("dm1_freeze", 32'(hzd_freeze), 32'd1);
    checkOutput("dm1_stall_if", 32'(hzd_stall_if), 32'd1);
    checkOutput("dm1_stall_dec", 32'(hzd_stall_dec), 32'd1);
    checkOutput("dm1_kill_dec", 32'(hzd_kill_dec), 32'd0);
    checkOutput("dm1_fwd1", 32'(hzd_fwd_src1), 32'd1);
    applyStimulus(5'd9, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("dm2_freeze", 32'(hzd_freeze), 32'd1);
    checkOutput("dm2_kill_ex", 32'(hzd_kill_ex), 32'd0);
    checkOutput("dm2_state", 32'(hzd_state), 32'(ST_DMISS));
    applyStimulus(5'd9, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(5'd9, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("dm4_freeze", 32'(hzd_freeze), 32'd1);
    checkOutput("dm4_sb_held", 32'(hzd_fwd_src1), 32'd1);
    applyStimulus(5'd9, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("dm_rel_freeze", 32'(hzd_freeze), 32'd0);
    checkOutput("dm_rel_stall_if", 32'(hzd_stall_if), 32'd0);
    checkOutput("dm_rel_fwd1", 32'(hzd_fwd_src1), 32'd1);
    applyIdle(1'b1);
    checkOutput("dm_flush_state", 32'(hzd_state), 32'(ST_FLUSH));
    checkOutput("dm_flush_kill_ex", 32'(hzd_kill_ex), 32'd1);
    checkOutput("dm_cnt", 32'(hzd_stall_cnt), 32'd4);
    applyIdle(1'b1);
    checkOutput("dm_flush2_kill_dec", 32'(hzd_kill_dec), 32'd1);
    checkOutput("dm_flush2_kill_ex", 32'(hzd_kill_ex), 32'd0);

    // Load-use coinciding with an instruction miss, then a long miss
    applyStimulus(5'd0, 5'd0, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(5'd3, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("lui_stall_dec", 32'(hzd_stall_dec), 32'd1);
    checkOutput("lui_kill_dec", 32'(hzd_kill_dec), 32'd0);
    checkOutput("lui_stall_if", 32'(hzd_stall_if), 32'd1);
    applyIdle(1'b0);
    checkOutput("im_state", 32'(hzd_state), 32'(ST_IMISS));
    checkOutput("im_kill_dec", 32'(hzd_kill_dec), 32'd1);
    checkOutput("im_stall_dec", 32'(hzd_stall_dec), 32'd0);
    for (int i = 0; i < 4; i++) applyIdle(1'b0);
    checkOutput("im_cnt", 32'(hzd_stall_cnt), 32'd9);
    checkOutput("sat_cnt", 32'(s_stall_cnt), 32'd7);
    checkOutput("im_state_hold", 32'(hzd_state), 32'(ST_IMISS));

    // Asynchronous reset in the middle of the miss
    #1;
    hzd_rst = 1'b1;
    #1;
    checkOutput("arst_stall_if", 32'(hzd_stall_if), 32'd1);
    checkOutput("arst_kill_dec", 32'(hzd_kill_dec), 32'd0);
    checkOutput("arst_state", 32'(hzd_state), 32'(ST_RUN));
    checkOutput("arst_cnt", 32'(hzd_stall_cnt), 32'd0);
    checkOutput("arst_sat_cnt", 32'(s_stall_cnt), 32'd0);
    @(negedge hzd_clk);
    hzd_il1_ack = 1'b1;
    hzd_rst = 1'b0;
    applyIdle(1'b1);
    checkOutput("post_rst_state", 32'(hzd_state), 32'(ST_RUN));
    checkOutput("post_rst_stall_if", 32'(hzd_stall_if), 32'd0);
    checkOutput("post_rst_cnt", 32'(hzd_stall_cnt), 32'd0);

    // A taken branch during an instruction miss goes to FLUSH
    applyIdle(1'b0);
    applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("imbr_state", 32'(hzd_state), 32'(ST_IMISS));
    checkOutput("imbr_stall_if", 32'(hzd_stall_if), 32'd1);
    applyIdle(1'b1);
    checkOutput("imbr_flush", 32'(hzd_state), 32'(ST_FLUSH));
    checkOutput("imbr_kill_ex", 32'(hzd_kill_ex), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
